// File: rtl/int_to_float_converter_pkg.sv
// Shared types and constants for the fixed-point to IEEE-754 single-precision converter.
package int_to_float_converter_pkg;

  localparam int C_FP_DWIDTH     = 32;
  localparam int C_FP_EXP_BIAS   = 127;
  localparam int C_FP_MANT_WIDTH = 23;

  typedef logic [C_FP_DWIDTH-1:0] float_t;

  function automatic float_t pack_float(input logic sign, input logic [7:0] exp,
                                        input logic [C_FP_MANT_WIDTH-1:0] mant);
    return {sign, exp, mant};
  endfunction

endpackage

// File: rtl/int_to_float_converter_leading_one_detector.sv
// Combinational priority encoder: index of the most significant set bit plus an all-zero flag.
module leading_one_detector #(
  parameter int G_WIDTH     = 24,
  parameter int G_POS_WIDTH = $clog2(G_WIDTH)
) (
  input  logic [G_WIDTH-1:0]     vec,
  output logic [G_POS_WIDTH-1:0] pos,
  output logic                   zero
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    pos  = '0;
    zero = 1'b1;
    for (int i = 0; i < G_WIDTH; i++) begin
      if (vec[i]) begin
        pos  = G_POS_WIDTH'(i);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/int_to_float_converter.sv
// Three-stage pipeline converting a signed fraction in [-1, 1) to an exact binary32 value.
module int_to_float_converter
  import int_to_float_converter_pkg::*;
#(
  parameter int G_DIN_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [G_DIN_WIDTH-1:0] din,
  input  logic                   din_valid,
  output logic                   din_ready,
  output float_t                 dout,
  output logic                   dout_valid,
  input  logic                   dout_ready
);

  localparam int C_POS_W    = $clog2(G_DIN_WIDTH);
  localparam int C_SIG_W    = C_FP_MANT_WIDTH + 1;
  localparam int C_EXP_BASE = C_FP_EXP_BIAS - (G_DIN_WIDTH - 1);

  // Handshake: a beat moves on any clock where valid and ready are both high;
  // the whole pipe advances together whenever the output slot is empty or being taken.
  logic advance;
  assign advance   = ~dout_valid | dout_ready;
  assign din_ready = advance & enable;

  // Stage 1: sign and magnitude; the magnitude of the most negative code fits unsigned.
  logic                   s1_valid;
  logic                   s1_sign;
  logic [G_DIN_WIDTH-1:0] s1_mag;
  logic [G_DIN_WIDTH-1:0] din_mag;

  assign din_mag = din[G_DIN_WIDTH-1] ? (~din + G_DIN_WIDTH'(1)) : din;

  // Stage 2: leading-one detect and normalise so the hidden bit lands on bit 23.
  logic                       s2_valid;
  logic                       s2_sign;
  logic                       s2_zero;
  logic [7:0]                 s2_exp;
  logic [C_FP_MANT_WIDTH-1:0] s2_mant;
  logic [C_POS_W-1:0]         lod_pos;
  logic                       lod_zero;
  logic [C_SIG_W-1:0]         sig;
  logic [4:0]                 shift_amt;

  leading_one_detector #(
    .G_WIDTH     (G_DIN_WIDTH),
    .G_POS_WIDTH (C_POS_W)
  ) u_lod (
    .vec  (s1_mag),
    .pos  (lod_pos),
    .zero (lod_zero)
  );

  assign shift_amt = 5'(C_FP_MANT_WIDTH) - 5'(lod_pos);
  assign sig       = C_SIG_W'(s1_mag) << shift_amt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_mag     <= '0;
      s2_valid   <= 1'b0;
      s2_sign    <= 1'b0;
      s2_zero    <= 1'b1;
      s2_exp     <= '0;
      s2_mant    <= '0;
      dout_valid <= 1'b0;
      dout       <= '0;
    end else if (!enable) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      dout_valid <= 1'b0;
    end else if (advance) begin
      s1_valid   <= din_valid;
      s1_sign    <= din[G_DIN_WIDTH-1];
      s1_mag     <= din_mag;
      s2_valid   <= s1_valid;
      s2_sign    <= s1_sign;
      s2_zero    <= lod_zero;
      s2_exp     <= 8'(C_EXP_BASE) + 8'(lod_pos);
      s2_mant    <= sig[C_FP_MANT_WIDTH-1:0];
      dout_valid <= s2_valid;
      // Stage 3: pack; zero always yields +0 since a zero sample has a clear sign bit.
      if (s2_valid) begin
        dout <= s2_zero ? '0 : pack_float(s2_sign, s2_exp, s2_mant);
      end
    end
  end

endmodule

// File: tb/tb_int_to_float_converter.sv
// Bench for int_to_float_converter: golden table, random streaming, backpressure, reset and enable.
module tb_int_to_float_converter;

  localparam int W = 24;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b1;
  logic [W-1:0]  din = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [31:0]   dout;
  logic          dout_valid;
  logic          dout_ready = 1'b1;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic lat_chk = 1'b0;
  logic chk_stable = 1'b0;
  logic [31:0] held;

  logic [31:0] exp_q[$];
  int          cyc_q[$];

  typedef struct {
    logic [W-1:0] d;
    logic [31:0]  f;
  } vec_t;
  vec_t tbl[6];

  int_to_float_converter #(.G_DIN_WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  always #5 clk = ~clk;

  // Reference: exact real value, re-encoded from the double-precision bit pattern.
  function automatic logic [31:0] ref_model(input logic [W-1:0] d);
    int          v;
    real         r;
    logic [63:0] b;
    logic [10:0] e;
    v = int'($signed(d));
    if (v == 0) return 32'h0;
    r = real'(v) / 8388608.0;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, req, $time);
    end
  endtask

  // Scoreboard and stability monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [31:0] e;
    int c;
    cyc++;
    if (reset_n) begin
      if (chk_stable) begin
        check("hold_valid", {31'b0, dout_valid}, 32'h1);
        check("hold_data", dout, held);
      end
      chk_stable = enable && dout_valid && !dout_ready;
      held = dout;
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got %h expected none", dout);
        end else begin
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          check("scoreboard", dout, e);
          if (lat_chk) check("latency", 32'(cyc - c), 32'd3);
        end
      end
      if (!enable) begin
        exp_q.delete();
        cyc_q.delete();
      end else if (din_valid && din_ready) begin
        exp_q.push_back(ref_model(din));
        cyc_q.push_back(cyc);
      end
    end
  end

  always @(negedge reset_n) begin
    exp_q.delete();
    cyc_q.delete();
    chk_stable = 1'b0;
  end

  task automatic drain(input int budget);
    int i;
    i = 0;
    while (i < budget && exp_q.size() != 0) begin
      @(posedge clk);
      i++;
    end
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int k;
    int waited;
    logic got;
    logic [W-1:0] bp_data[5];

    tbl[0] = '{24'h000000, 32'h00000000};
    tbl[1] = '{24'h000001, 32'h34000000};
    tbl[2] = '{24'h400000, 32'h3F000000};
    tbl[3] = '{24'h7FFFFF, 32'h3F7FFFFE};
    tbl[4] = '{24'h800000, 32'hBF800000};
    tbl[5] = '{24'hC00000, 32'hBF000000};

    // Reset state
    #7;
    check("reset_dout_valid", {31'b0, dout_valid}, 32'h0);
    check("reset_dout", dout, 32'h0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;

    // Golden table; first transfer lands on the first clock after reset release
    for (int t = 0; t < 6; t++) begin
      din = tbl[t].d;
      din_valid = 1'b1;
      @(negedge clk);
      check("din_ready_idle", {31'b0, din_ready}, 32'h1);
      @(posedge clk);
      #1 din_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
        @(negedge clk);
        if (dout_valid) begin
          got = 1'b1;
          check("golden", dout, tbl[t].f);
        end
      end
      if (!got) begin
        n_vec++;
        n_err++;
        $display("FAIL golden_timeout: got no output expected %h", tbl[t].f);
      end
      @(posedge clk);
      #1;
    end

    // Streaming with latency check
    lat_chk = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      din = W'($urandom);
      din_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
    drain(20);
    lat_chk = 1'b0;

    // Backpressure: 5 samples offered while the sink is blocked for 10 clocks
    for (int i = 0; i < 5; i++) bp_data[i] = W'($urandom);
    dout_ready = 1'b0;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      din_valid = (k < 5);
      din = bp_data[k < 5 ? k : 4];
      @(negedge clk);
      if (din_valid && din_ready) k++;
      @(posedge clk);
      #1;
    end
    check("bp_accepts", 32'(k), 32'd3);
    check("bp_din_ready", {31'b0, din_ready}, 32'h0);
    check("bp_dout", dout, ref_model(bp_data[0]));
    dout_ready = 1'b1;
    waited = 0;
    while (k < 5 && waited < 20) begin
      din_valid = 1'b1;
      din = bp_data[k];
      @(negedge clk);
      if (din_ready) k++;
      @(posedge clk);
      #1;
      waited++;
    end
    din_valid = 1'b0;
    check("bp_all_accepted", 32'(k), 32'd5);
    drain(20);

    // Random valid and ready
    for (int i = 0; i < 600; i++) begin
      din = W'($urandom);
      din_valid = 1'($urandom_range(0, 1));
      dout_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
    dout_ready = 1'b1;
    drain(30);

    // Reset with 3 samples in flight
    for (int i = 0; i < 3; i++) begin
      din = W'($urandom);
      din_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("rst_dout_valid", {31'b0, dout_valid}, 32'h0);
    check("rst_dout", dout, 32'h0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    din = 24'h200000;
    din_valid = 1'b1;
    @(negedge clk);
    check("first_after_reset", {31'b0, din_ready}, 32'h1);
    @(posedge clk);
    #1 din_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("no_stale", {31'b0, dout_valid}, 32'h0);
    end
    drain(10);

    // Enable drop with a full pipeline
    dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din = W'($urandom);
      din_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    check("en_full", {31'b0, dout_valid}, 32'h1);
    enable = 1'b0;
    @(negedge clk);
    check("en_din_ready", {31'b0, din_ready}, 32'h0);
    @(posedge clk);
    #1;
    check("en_cleared", {31'b0, dout_valid}, 32'h0);
    enable = 1'b1;
    dout_ready = 1'b1;
    din_valid = 1'b0;
    #1;
    check("en_resume_ready", {31'b0, din_ready}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      din = W'($urandom);
      din_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
    drain(20);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/int_to_float_converter.md
INT_TO_FLOAT_CONVERTER -- requirements
Module: int_to_float_converter

Interface
REQ-001 The block SHALL have parameter G_DIN_WIDTH, default 24, meaning the signed two's-complement input sample width; legal range 2..24.
REQ-002 The block SHALL have localparam C_FP_DWIDTH, value 32, meaning the IEEE-754 single-precision output width.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-004 The block SHALL have port reset_n, input, 1 bit, the asynchronous active-low reset.
REQ-005 The block SHALL have port enable, input, 1 bit; low flushes the pipeline synchronously.
REQ-006 The block SHALL have port din, input, G_DIN_WIDTH bits, the signed fixed-point sample with full scale equal to [-1, 1).
REQ-007 The block SHALL have port din_valid, input, 1 bit, qualifying din.
REQ-008 The block SHALL have port din_ready, output, 1 bit; a transfer occurs on a clock where din_valid and din_ready are both 1.
REQ-009 The block SHALL have port dout, output, C_FP_DWIDTH bits, the float result that feeds the polynomial estimator din.
REQ-010 The block SHALL have port dout_valid, output, 1 bit, qualifying dout.
REQ-011 The block SHALL have port dout_ready, input, 1 bit, the downstream acceptance.

Function
REQ-012 Conversion SHALL be exact: dout = din / 2^(G_DIN_WIDTH-1) as IEEE-754 binary32, with no rounding.
REQ-013 Sign: dout[31] SHALL equal din[MSB].
REQ-014 Magnitude mag = |din| SHALL be held in G_DIN_WIDTH bits, so the most negative code yields mag = 2^(G_DIN_WIDTH-1) with no overflow.
REQ-015 Zero input SHALL produce 0x00000000; negative zero SHALL never be produced.
REQ-016 For mag ≠ 0, with p = index of the leading one of mag: exponent SHALL be 127 + p − (G_DIN_WIDTH−1), and mantissa SHALL be bits [22:0] of mag shifted left by (23−p).
REQ-017 Denormals, infinity and NaN are unreachable and SHALL NOT be generated.
REQ-018 The pipeline SHALL have 3 register stages:
 - S1: capture sign and mag.
 - S2: leading-one detect and normalising shift.
 - S3: pack the output into dout.
REQ-019 Latency from an accepted din to dout_valid SHALL be 3 clocks when not stalled.
REQ-020 Throughput SHALL be 1 sample per clock while dout_ready = 1.
REQ-021 Stall: advance = ~dout_valid | dout_ready.
 - All stages SHALL shift only when advance = 1.
 - din_ready SHALL equal advance, combinationally.
REQ-022 dout and dout_valid SHALL remain stable while dout_valid = 1 and dout_ready = 0.
REQ-023 Each stage SHALL carry its own valid bit; bubbles propagate and never produce dout_valid.
REQ-024 No sample SHALL be lost, duplicated or reordered under any dout_ready pattern.
REQ-025 With enable = 0:
 - all stage valid bits and dout_valid SHALL clear on the next clock;
 - din_ready SHALL be 0;
 - data registers are don't-care.
REQ-026 A simultaneous input transfer and output transfer SHALL both complete in the same clock.

Reset
REQ-027 reset_n low SHALL immediately clear all valid bits, dout_valid = 0 and dout = 0x00000000, independent of clk.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight samples, with no partial output after release.
REQ-029 The first transfer SHALL be accepted on the first clock after reset_n deasserts, given enable = 1.

Structure
REQ-030 A shared package SHALL hold:
 - the float_t typedef (logic [31:0]);
 - C_FP_DWIDTH = 32, C_FP_EXP_BIAS = 127, C_FP_MANT_WIDTH = 23.
REQ-031 A single sub-module, leading_one_detector, SHALL be used: a parameterised combinational priority encoder returning p and a zero flag.
REQ-032 No floating-point IP cores SHALL be instantiated.

Verification (G_DIN_WIDTH = 24)
REQ-033 Golden values: each of the following inputs -> the listed dout:
 - 0x000000 -> 0x00000000
 - 0x000001 -> 0x34000000
 - 0x400000 -> 0x3F000000
 - 0x7FFFFF -> 0x3F7FFFFE
 - 0x800000 -> 0xBF800000
 - 0xC00000 -> 0xBF000000
REQ-034 Streaming: 1000 random samples back-to-back with dout_ready = 1 -> dout_valid exactly 3 clocks after each accept, and every dout matches a reference model.
REQ-035 Backpressure:
 - Stimulus: stream 5 samples while dout_ready = 0 for 10 clocks.
 - din_ready SHALL drop after 3 accepts and dout SHALL hold stable.
 - On release, all 5 outputs SHALL appear in order.
REQ-036 Random ready: random din_valid and dout_ready at 50% each -> scoreboard shows zero loss, duplication or reorder.
REQ-037 Reset mid-stream: assert reset_n low between clock edges with 3 samples in flight -> dout_valid = 0 immediately, and no stale output after release.
REQ-038 Enable: drop enable for 1 clock with a full pipeline -> all valid bits clear and din_ready = 0; normal operation resumes when enable returns high.
